pipe_reg: RTL
=============

# pipe_reg

Parametrised multi-stage pipeline register: `WIDTH`-bit data, `DEPTH` register slices, valid/ready handshake, bubble collapse, synchronous flush and occupancy count. It is the general form of the plain resettable register. It is dropped between datapath blocks wherever a timing cut or a short elastic buffer is needed without writing a FIFO.

## Interface
- `WIDTH`, 32, data width in bits (≥1)
- `DEPTH`, 2, number of register slices (≥1)
- `RESET_VAL`, '0, value loaded into every data slice on reset and flush

- `clk`  in  1  single clock; all state updates on posedge
- `reset_n`  in  1  asynchronous, active-low reset
- `flush`  in  1  synchronous clear of all slices
- `in_valid`  in  1  upstream word present
- `in_data`  in  WIDTH  upstream word
- `in_ready`  out  1  pipe accepts `in_data` this cycle
- `out_valid`  out  1  last slice holds a word
- `out_data`  out  WIDTH  last slice data
- `out_ready`  in  1  downstream takes the word this cycle
- `count`  out  $clog2(DEPTH+1)  number of valid slices

## Operation
- Each slice i (0 = input side, DEPTH-1 = output side) holds `data_q[i]` and `valid_q[i]`.
- Slice readiness: `rdy[i] = !valid_q[i] | rdy[i+1]`, with `rdy[DEPTH] = out_ready`. The chain is combinational; there is no skid buffer.
- `in_ready = rdy[0] & !flush`.
- Accept: `in_valid & in_ready` loads `in_data` into slice 0 and sets `valid_q[0]`.
- Advance: if `rdy[i+1]`, slice i's content moves to slice i+1. A slice that receives no word and whose content has moved clears its valid.
- Bubble collapse: an empty slice always takes from its predecessor, even while the output is stalled. The pipe therefore fills to DEPTH words under backpressure.
- `out_valid = valid_q[DEPTH-1]` and `out_data = data_q[DEPTH-1]`, both taken directly from flops.
- Data in slices with valid=0 is don't-care to consumers, but it must not be X after reset.
- `count` is a registered popcount of `valid_q`:
  - +1 on accept only;
  - −1 on emit (`out_valid & out_ready`) only;
  - unchanged when accept and emit happen together;
  - range 0..DEPTH, never wraps.
- Flush, when asserted at a clock edge:
  - all valids clear, all data slices become `RESET_VAL`, `count` becomes 0;
  - it has priority over accept and advance in the same cycle;
  - no word is accepted, and the output word on that edge is dropped even if `out_ready` is high.
- Order is preserved. Every accepted word is emitted exactly once unless a flush or reset intervenes.

## Timing
- Reset (`reset_n` = 0) acts immediately, without a clock edge:
  - `valid_q` all 0, `data_q` all `RESET_VAL`, `count` = 0;
  - `out_valid` = 0, `out_data` = `RESET_VAL`;
  - `in_ready` = 1 (when `flush` = 0).
- Reset deassertion is taken synchronously by the integrator. The first accept is possible on the first posedge after release.
- Latency with `out_ready` held high: a word accepted at edge N is visible on `out_data`/`out_valid` after edge N+DEPTH−1. With DEPTH=1 it appears after the accepting edge.
- Throughput: one word per cycle sustained while `out_ready` = 1.
- Full pipe (`count` = DEPTH), `out_ready` = 0: `in_ready` = 0 in the same cycle.
- Full pipe, `out_ready` = 1: `in_ready` = 1. Accept and emit on the same edge, `count` stays at DEPTH.
- Upstream may not drop `in_valid` or change `in_data` while `in_valid & !in_ready`. Downstream sees the same rule on `out_*`: the pipe holds `out_data` stable while `out_valid & !out_ready`.
- `reset_n` falling mid-stream discards all contents immediately. Any handshake in progress in that cycle is void.

## Structure
- Package `pipe_pkg`:
  - `PIPE_DEFAULT_WIDTH` = 32;
  - `PIPE_DEFAULT_DEPTH` = 2;
  - function `cnt_w(depth)` returning `$clog2(depth+1)`.
- Sub-module `pipe_stage`: one slice with data and valid flops. Ports are `clk`, `reset_n`, `flush`, `up_valid`, `up_data`, `dn_ready`, `rdy` out, `valid`, `data`. It is instantiated DEPTH times with a generate loop.
- The top level holds the ready chain, the `count` register and the output assigns.

## Test plan
- Reset: assert `reset_n` = 0 between edges, no clock → `out_valid` = 0, `out_data` = 0, `count` = 0, `in_ready` = 1 immediately.
- Streaming, DEPTH=3, `out_ready` = 1: push 10, 11, 12 on consecutive edges → `out_data` shows 10 after the 3rd edge, then 11 and 12 back-to-back; `count` peaks at 3.
- Backpressure, DEPTH=3, `out_ready` = 0: offer 1, 2, 3, 4 → 1–3 accepted, `in_ready` = 0 with 4 held, `count` = 3. Raise `out_ready` → output 1, 2, 3, 4 in order with no duplicates; the edge that emits 1 also accepts 4, so `count` stays 3.
- Bubble collapse, `out_ready` = 0: push 0xA, idle one cycle, push 0xB → `count` = 2. On release, 0xA and 0xB are emitted on consecutive cycles.
- Flush: `count` = 2, `flush` = 1 with `in_valid` = 1 and `out_ready` = 1 → after the edge `count` = 0, `out_valid` = 0, `out_data` = `RESET_VAL`; the offered word is never emitted.
- Mid-stream async reset: pipe full with 5, 6, 7, `reset_n` pulsed low between edges → all outputs clear at once. After release, push 9 → exactly one word, 9, emerges.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared defaults and width helpers for the pipe_reg pipeline register.
package pipe_pkg;

  localparam int unsigned PIPE_DEFAULT_WIDTH = 32;
  localparam int unsigned PIPE_DEFAULT_DEPTH = 2;

  // Bits needed to hold an occupancy value in the range 0..depth.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One pipeline slice: a data word plus its valid flag, refilled whenever it is empty or drains.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int unsigned           WIDTH     = PIPE_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             dn_ready,
  output logic             rdy,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  assign rdy = !valid | dn_ready;

  // Data only loads with a real word so idle slices keep their last value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
      data  <= RESET_VAL;
    end else if (flush) begin
      valid <= 1'b0;
      data  <= RESET_VAL;
    end else if (rdy) begin
      valid <= up_valid;
      if (up_valid) begin
        data <= up_data;
      end
    end
  end

endmodule

// File: rtl/pipe_reg.sv
// Multi-slice elastic pipeline register with bubble collapse, synchronous flush and occupancy count.
module pipe_reg
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH     = PIPE_DEFAULT_WIDTH,
  parameter int unsigned      DEPTH     = PIPE_DEFAULT_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      flush,
  input  logic                      in_valid,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  input  logic                      out_ready,
  output logic [cnt_w(DEPTH)-1:0]   count
);

  localparam int unsigned CW = cnt_w(DEPTH);

  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] up_valid;
  logic [WIDTH-1:0] up_data [DEPTH];
  logic [DEPTH-1:0] dn_rdy;
  logic [DEPTH-1:0] rdy_s;
  logic             accept;
  logic             emit;

  // Downstream readiness per slice, built from the valid flops so no comb loop crosses instances.
  always_comb begin
    logic r;
    dn_rdy = '0;
    r      = out_ready;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      dn_rdy[i] = r;
      r         = r | !valid_q[i];
    end
  end

  assign in_ready = rdy_s[0] & !flush;
  assign accept   = in_valid & in_ready;
  assign emit     = valid_q[DEPTH-1] & out_ready & !flush;

  for (genvar i = 0; i < int'(DEPTH); i++) begin : g_slice
    if (i == 0) begin : g_head
      assign up_valid[i] = accept;
      assign up_data[i]  = in_data;
    end else begin : g_body
      assign up_valid[i] = valid_q[i-1];
      assign up_data[i]  = data_q[i-1];
    end

    pipe_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk      (clk),
      .reset_n  (reset_n),
      .flush    (flush),
      .up_valid (up_valid[i]),
      .up_data  (up_data[i]),
      .dn_ready (dn_rdy[i]),
      .rdy      (rdy_s[i]),
      .valid    (valid_q[i]),
      .data     (data_q[i])
    );
  end

  // Interior slice readiness is recomputed in dn_rdy; only the head's is consumed.
  if (DEPTH > 1) begin : g_tail_rdy
    logic unused_rdy;
    assign unused_rdy = ^rdy_s[DEPTH-1:1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (accept && !emit) begin
      count <= count + CW'(1);
    end else if (emit && !accept) begin
      count <= count - CW'(1);
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

endmodule
